tau_gemm_engine: RTL
====================

// Module: tau_gemm_engine
// PURPOSE
//  Parametrised successor to the square temporal GEMM array: computes OUT = IN0(MxK) * IN1(KxN)
//  with an MxN grid of bit-serial PEs, WIDTH cycles per k-step, K steps per job.
//  Adds valid/ready handshakes on both sides, rectangular shapes, a signed mode and a
//  tile-accumulate mode. Sits between the operand tile buffers and the result writeback.
// PARAMETERS
//  M       4                    rows of IN0 / OUT
//  N       4                    columns of IN1 / OUT
//  K       4                    inner dimension (>=1)
//  WIDTH   8                    operand bits (>=2)
//  SIGNED  0                    1: two's-complement operands and results; 0: unsigned
//  ACC_W   2*WIDTH+$clog2(K)+1  accumulator/result width
// PORTS
//  clk        in   1                clock
//  reset_n    in   1                async active-low reset
//  in_valid   in   1                job operands valid
//  in_ready   out  1                engine can accept a job (IDLE only)
//  in0        in   [M][K][WIDTH]    left matrix, in0[i][k]
//  in1        in   [K][N][WIDTH]    right matrix, in1[k][j]
//  acc_en     in   1                sampled with job: 1 = add onto current OUT, 0 = clear first
//  out        out  [M][N][ACC_W]    result matrix, out[i][j]
//  out_valid  out  1                result valid; held until out_ready
//  out_ready  in   1                consumer takes result
//  busy       out  1                state != IDLE
// BEHAVIOUR
//  Reset: async on reset_n low -> state IDLE; k_cnt, bit_cnt, every acc reg = 0;
//   out = 0, out_valid = 0, in_ready = 1, busy = 0. Mid-job reset discards the job; no output.
//  FSM: IDLE -> COMPUTE on (in_valid & in_ready). COMPUTE -> DONE after the last step
//   (k_cnt==K-1 & bit_cnt==WIDTH-1). DONE -> IDLE on out_ready.
//  Accept edge: in0, in1, acc_en registered into operand regs; if acc_en==0 all accs cleared
//   to 0 on the same edge, else retained; k_cnt = bit_cnt = 0.
//  COMPUTE: one bit-step per cycle. PE(i,j) uses a = in0[i][k_cnt], b = in1[k_cnt][j], bit = bit_cnt:
//   if b[bit]: acc += ext(a) << bit, except SIGNED && bit==WIDTH-1: acc -= ext(a) << bit.
//   ext = sign-extend (SIGNED) or zero-extend to ACC_W. Arithmetic is modulo 2^ACC_W (wraps).
//   bit_cnt wraps WIDTH-1 -> 0 and increments k_cnt.
//  Latency: out_valid rises exactly K*WIDTH cycles after the accept edge; it is then
//   combinationally from DONE and stays high until the out_ready edge.
//  out = acc regs always; it is stable from entry to DONE until the next accept edge
//   (it remains readable in IDLE).
//  in_ready = (state==IDLE). in_valid while not IDLE is ignored, with no queuing.
//  In DONE with out_ready=1: one cycle in DONE, then IDLE. in_ready is high on the following
//   cycle; there is no same-cycle DONE->COMPUTE bypass.
//  out_ready while not in DONE: ignored.
//  Operands may change after the accept edge without effect. in_valid need not be held.
// STRUCTURE
//  Package tau_gemm_pkg: state enum {IDLE, COMPUTE, DONE}, function acc_width(WIDTH,K),
//   localparams for counter widths ($clog2(K), $clog2(WIDTH), min 1 bit).
//  Sub-module tau_bs_pe (one per (i,j)) holds the acc reg. Inputs: clk, reset_n, clr, step,
//   a, b, bit_idx, and SIGNED/WIDTH/ACC_W params. Implements the bit-step update above.
//  Top: FSM, k/bit counters, operand registers, column/row select muxes, M x N generate of PEs.
// TESTING
//  1 M=N=K=2,WIDTH=4,unsigned; in0=I, in1=[[3,5],[7,9]], acc_en=0 -> out=[[3,5],[7,9]],
//    out_valid exactly 8 cycles after accept.
//  2 All operands 15, K=2, WIDTH=4 -> every out = 450; no wrap (ACC_W=10).
//  3 SIGNED=1,K=1,WIDTH=4: in0=-8, in1=7 -> out=-56; in0=-8, in1=-8 -> +64.
//  4 Job A (acc_en=0) then job B = same operands (acc_en=1) -> out = 2x job A result.
//    Job C (acc_en=0) -> out = C result only.
//  5 Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new data ->
//    out/out_valid stable, in_ready=0, no job accepted. out_ready=1 -> in_ready=1 the cycle
//    after leaving DONE.
//  6 Drop reset_n at K*WIDTH/2 cycles into COMPUTE -> immediate IDLE, out=0, out_valid=0.
//    Next job is correct from a clean state.

Source files
------------

// File: rtl/tau_gemm_pkg.sv
// Shared types and sizing helpers for the bit-serial temporal GEMM engine.
// Included by the engine top and by each processing element.
package tau_gemm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int CNT_MIN_W = 1;

    // Room for WIDTHxWIDTH products summed K times, plus a sign bit.
    function automatic int acc_width(input int width, input int k);
        return 2 * width + $clog2(k) + 1;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : CNT_MIN_W;
    endfunction

endpackage

// File: rtl/tau_bs_pe.sv
// Bit-serial PE: adds (or, for a signed MSB, subtracts) the shifted
// multiplicand whenever the selected multiplier bit is set.
module tau_bs_pe
    import tau_gemm_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0,
    parameter int ACC_W  = 2 * WIDTH + 1,
    parameter int BW     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [BW-1:0]    bit_idx,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_sh;
    logic             w_neg;
    logic             w_bit;

    assign w_ext = SIGNED ? {{(ACC_W-WIDTH){a[WIDTH-1]}}, a}
                          : {{(ACC_W-WIDTH){1'b0}}, a};
    assign w_sh  = w_ext << bit_idx;
    assign w_neg = SIGNED && (bit_idx == BW'(WIDTH-1));
    assign w_bit = b[bit_idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (step && w_bit) begin
            r_acc <= w_neg ? r_acc - w_sh : r_acc + w_sh;
        end
    end

    assign acc = r_acc;

endmodule

// File: rtl/tau_gemm_engine.sv
// MxN grid of bit-serial PEs computing IN0(MxK) * IN1(KxN), one
// multiplier bit per cycle, with valid/ready handshakes on both sides.
module tau_gemm_engine
    import tau_gemm_pkg::*;
#(
    parameter int M      = 4,
    parameter int N      = 4,
    parameter int K      = 4,
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0,
    parameter int ACC_W  = acc_width(WIDTH, K)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [M-1:0][K-1:0][WIDTH-1:0]    in0,
    input  logic [K-1:0][N-1:0][WIDTH-1:0]    in1,
    input  logic                              acc_en,
    output logic [M-1:0][N-1:0][ACC_W-1:0]    out,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy
);

    localparam int KW = cnt_width(K);
    localparam int BW = cnt_width(WIDTH);

    state_t                           r_state;
    state_t                           w_next;
    logic [KW-1:0]                    r_k;
    logic [BW-1:0]                    r_bit;
    logic [M-1:0][K-1:0][WIDTH-1:0]   r_in0;
    logic [K-1:0][N-1:0][WIDTH-1:0]   r_in1;
    logic                             w_accept;
    logic                             w_bit_last;
    logic                             w_last;
    logic                             w_clr;
    logic                             w_step;

    assign w_accept   = in_valid && (r_state == IDLE);
    assign w_bit_last = (r_bit == BW'(WIDTH-1));
    assign w_last     = w_bit_last && (r_k == KW'(K-1));
    assign w_clr      = w_accept && !acc_en;
    assign w_step     = (r_state == COMPUTE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_next = COMPUTE;
            COMPUTE: if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    // Operands are captured once so the producer may move on after accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_k   <= '0;
            r_bit <= '0;
            r_in0 <= '0;
            r_in1 <= '0;
        end else if (w_accept) begin
            r_k   <= '0;
            r_bit <= '0;
            r_in0 <= in0;
            r_in1 <= in1;
        end else if (w_step) begin
            if (w_bit_last) begin
                r_bit <= '0;
                r_k   <= (r_k == KW'(K-1)) ? '0 : r_k + 1'b1;
            end else begin
                r_bit <= r_bit + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            tau_bs_pe #(
                .WIDTH  (WIDTH),
                .SIGNED (SIGNED),
                .ACC_W  (ACC_W),
                .BW     (BW)
            ) u_pe (
                .clk     (clk),
                .reset_n (reset_n),
                .clr     (w_clr),
                .step    (w_step),
                .a       (r_in0[i][r_k]),
                .b       (r_in1[r_k][j]),
                .bit_idx (r_bit),
                .acc     (out[i][j])
            );
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);

endmodule
